// File: rtl/srio_input_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : srio_input_reader_if
//  Brief    : Upstream beat bus and downstream stream bus of srio_input_reader
//  Revision : 1.0  initial release
// ============================================================================
interface srio_input_reader_if #(
   parameter int DATA_WIDTH        = 64,
   parameter int DATA_LENGTH_WIDTH = 20
);
   logic [DATA_WIDTH-1:0]        data_in;
   logic                         data_valid_in;
   logic                         data_first_in;
   logic [DATA_WIDTH/8-1:0]      data_keep_in;
   logic [DATA_LENGTH_WIDTH-1:0] data_len_in;
   logic                         data_last_in;
   logic                         data_ready_out;
   logic                         ack_o;
   logic                         output_tready_in;
   logic [DATA_WIDTH-1:0]        output_tdata;
   logic                         output_tvalid;
   logic [DATA_WIDTH/8-1:0]      output_tkeep;
   logic                         output_tlast;
   logic                         output_tfirst;
   logic [7:0]                   output_data_len;
   logic                         output_done;

   modport slave (
      input  data_in, data_valid_in, data_first_in, data_keep_in,
             data_len_in, data_last_in, output_tready_in,
      output data_ready_out, ack_o, output_tdata, output_tvalid,
             output_tkeep, output_tlast, output_tfirst, output_data_len,
             output_done
   );

   modport master (
      output data_in, data_valid_in, data_first_in, data_keep_in,
             data_len_in, data_last_in, output_tready_in,
      input  data_ready_out, ack_o, output_tdata, output_tvalid,
             output_tkeep, output_tlast, output_tfirst, output_data_len,
             output_done
   );
endinterface
`default_nettype wire

// File: rtl/srio_input_reader.sv
`default_nettype none
// ============================================================================
//  Module   : srio_input_reader
//  Brief    : Single-packet store-and-forward buffer, replays as a stream
//  Revision : 1.0  initial release
// ============================================================================
module srio_input_reader #(
   parameter int DATA_WIDTH        = 64,
   parameter int DATA_LENGTH_WIDTH = 20,
   parameter int RAM_ADDR_WIDTH    = 10
) (
   input  wire logic          clk,
   input  wire logic          reset,
   srio_input_reader_if.slave bus
);

   localparam int c_KW = DATA_WIDTH / 8;
   localparam logic [RAM_ADDR_WIDTH:0] c_DEPTH = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
   localparam logic [RAM_ADDR_WIDTH:0] c_ONE   = {{RAM_ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WRITE      = 3'd1,
      S_READ_START = 3'd2,
      S_READ       = 3'd3,
      S_DONE       = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [c_KW+DATA_WIDTH-1:0] r_mem [0:(1<<RAM_ADDR_WIDTH)-1];
   logic [c_KW+DATA_WIDTH-1:0] r_mem_q;

   logic [RAM_ADDR_WIDTH:0]      r_cnt;
   logic [RAM_ADDR_WIDTH:0]      r_rd_addr;
   logic                         r_rd_vld;
   logic                         r_rd_first;
   logic                         r_rd_last;
   logic [c_KW-1:0]              r_last_keep;
   logic [DATA_LENGTH_WIDTH-1:0] r_byte_len_unused;
   logic                         r_ready;
   logic                         r_ack;
   logic [7:0]                   r_len_out;
   logic                         r_done;
   logic [DATA_WIDTH-1:0]        r_tdata;
   logic [c_KW-1:0]              r_tkeep;
   logic                         r_tvalid;
   logic                         r_tfirst;
   logic                         r_tlast;

   logic                         w_wr_en;
   logic [RAM_ADDR_WIDTH-1:0]    w_wr_addr;
   logic [RAM_ADDR_WIDTH:0]      w_cnt_next;
   logic                         w_pkt_start;
   logic                         w_take_last;
   logic                         w_rd_en;
   logic [RAM_ADDR_WIDTH:0]      w_rd_addr;
   logic                         w_out_adv;
   logic                         w_xfer;

   assign w_out_adv = !r_tvalid || bus.output_tready_in;
   assign w_xfer    = r_tvalid && bus.output_tready_in;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_wr_en     = 1'b0;
      w_wr_addr   = '0;
      w_cnt_next  = r_cnt;
      w_pkt_start = 1'b0;
      w_take_last = 1'b0;
      w_rd_en     = 1'b0;
      w_rd_addr   = r_rd_addr;
      unique case (r_state)
         S_IDLE: begin
            if (bus.data_valid_in && bus.data_first_in) begin
               w_wr_en     = 1'b1;
               w_cnt_next  = c_ONE;
               w_pkt_start = 1'b1;
               if (bus.data_last_in) begin
                  w_take_last = 1'b1;
                  w_next      = S_READ_START;
               end else begin
                  w_next = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (bus.data_valid_in) begin
               if (bus.data_first_in) begin
                  w_wr_en     = 1'b1;
                  w_cnt_next  = c_ONE;
                  w_pkt_start = 1'b1;
               end else if (r_cnt < c_DEPTH) begin
                  w_wr_en    = 1'b1;
                  w_wr_addr  = r_cnt[RAM_ADDR_WIDTH-1:0];
                  w_cnt_next = r_cnt + c_ONE;
               end
               if (bus.data_last_in) begin
                  w_take_last = 1'b1;
                  w_next      = S_READ_START;
               end
            end
         end
         S_READ_START: begin
            w_rd_en   = 1'b1;
            w_rd_addr = '0;
            w_next    = S_READ;
         end
         S_READ: begin
            // Refill the prefetch stage whenever it is empty or being drained.
            w_rd_en = (r_rd_addr < r_cnt) && (!r_rd_vld || w_out_adv);
            if (w_xfer && r_tlast) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_addr] <= {bus.data_keep_in, bus.data_in};
      if (w_rd_en) r_mem_q <= r_mem[w_rd_addr[RAM_ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt             <= '0;
         r_rd_addr         <= '0;
         r_rd_vld          <= 1'b0;
         r_rd_first        <= 1'b0;
         r_rd_last         <= 1'b0;
         r_last_keep       <= '0;
         r_byte_len_unused <= '0;
         r_ready           <= 1'b1;
         r_ack             <= 1'b0;
         r_len_out         <= '0;
         r_done            <= 1'b0;
         r_tdata           <= '0;
         r_tkeep           <= '0;
         r_tvalid          <= 1'b0;
         r_tfirst          <= 1'b0;
         r_tlast           <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_next;
         r_ready <= (w_next == S_IDLE) || (w_next == S_WRITE);
         r_ack   <= w_take_last;
         r_done  <= (r_state == S_READ) && (w_next == S_DONE);
         if (w_pkt_start) r_byte_len_unused <= bus.data_len_in;
         if (w_take_last) begin
            r_last_keep <= bus.data_keep_in;
            r_len_out   <= w_cnt_next[7:0];
         end

         if (w_rd_en) begin
            r_rd_vld   <= 1'b1;
            r_rd_addr  <= w_rd_addr + c_ONE;
            r_rd_first <= (w_rd_addr == '0);
            r_rd_last  <= (w_rd_addr == r_cnt - c_ONE);
         end else if (w_out_adv) begin
            r_rd_vld <= 1'b0;
         end

         // The final beat takes the latched last keep so a saturated packet still ends correctly.
         if (w_out_adv) begin
            if (r_rd_vld) begin
               r_tdata  <= r_mem_q[DATA_WIDTH-1:0];
               r_tkeep  <= r_rd_last ? r_last_keep : r_mem_q[DATA_WIDTH +: c_KW];
               r_tvalid <= 1'b1;
               r_tfirst <= r_rd_first;
               r_tlast  <= r_rd_last;
            end else begin
               r_tvalid <= 1'b0;
               r_tfirst <= 1'b0;
               r_tlast  <= 1'b0;
            end
         end
      end
   end

   assign bus.data_ready_out  = r_ready;
   assign bus.ack_o           = r_ack;
   assign bus.output_tdata    = r_tdata;
   assign bus.output_tvalid   = r_tvalid;
   assign bus.output_tkeep    = r_tkeep;
   assign bus.output_tlast    = r_tlast;
   assign bus.output_tfirst   = r_tfirst;
   assign bus.output_data_len = r_len_out;
   assign bus.output_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_srio_input_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srio_input_reader
//  Brief    : Directed self-checking bench for srio_input_reader
//  Revision : 1.0  initial release
// ============================================================================
module tb_srio_input_reader;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   srio_input_reader_if #(.DATA_WIDTH(64), .DATA_LENGTH_WIDTH(20)) bus ();

   srio_input_reader #(
      .DATA_WIDTH(64), .DATA_LENGTH_WIDTH(20), .RAM_ADDR_WIDTH(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   int          cyc_used;
   logic [63:0] exp_d [8];
   logic [7:0]  exp_k [8];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                            input logic f, input logic l, input logic [19:0] len);
      bus.data_in       = d;
      bus.data_keep_in  = k;
      bus.data_first_in = f;
      bus.data_last_in  = l;
      bus.data_len_in   = len;
      bus.data_valid_in = 1'b1;
      tick();
      bus.data_valid_in = 1'b0;
      bus.data_first_in = 1'b0;
      bus.data_last_in  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_ready"}, 128'(bus.data_ready_out),  128'd1);
      check({p, "_ack"},   128'(bus.ack_o),           128'd0);
      check({p, "_valid"}, 128'(bus.output_tvalid),   128'd0);
      check({p, "_first"}, 128'(bus.output_tfirst),   128'd0);
      check({p, "_last"},  128'(bus.output_tlast),    128'd0);
      check({p, "_keep"},  128'(bus.output_tkeep),    128'd0);
      check({p, "_data"},  128'(bus.output_tdata),    128'd0);
      check({p, "_len"},   128'(bus.output_data_len), 128'd0);
      check({p, "_done"},  128'(bus.output_done),     128'd0);
   endtask

   // Called with the first beat already valid; bit i of mask stalls drain cycle i.
   task automatic drain(input string p, input int n, input logic [63:0] mask, output int cycles);
      int           idx = 0;
      int           cyc = 0;
      logic         prev_stall = 1'b0;
      logic [127:0] snap = '0;
      logic [127:0] cur;
      while (idx < n && cyc < 64) begin
         bus.output_tready_in = !mask[cyc];
         cur = {53'd0, bus.output_tvalid, bus.output_tfirst, bus.output_tlast,
                bus.output_tkeep, bus.output_tdata};
         if (prev_stall) check({p, "_hold"}, cur, snap);
         prev_stall = 1'b0;
         if (bus.output_tvalid) begin
            if (bus.output_tready_in) begin
               check({p, "_data"},  128'(bus.output_tdata),  128'(exp_d[idx]));
               check({p, "_keep"},  128'(bus.output_tkeep),  128'(exp_k[idx]));
               check({p, "_first"}, 128'(bus.output_tfirst), 128'(idx == 0));
               check({p, "_last"},  128'(bus.output_tlast),  128'(idx == n - 1));
               idx++;
            end else begin
               prev_stall = 1'b1;
               snap       = cur;
            end
         end
         cyc++;
         tick();
      end
      bus.output_tready_in = 1'b0;
      check({p, "_beats"}, 128'(idx), 128'(n));
      cycles = cyc;
   endtask

   initial begin
      bus.data_in          = '0;
      bus.data_valid_in    = 1'b0;
      bus.data_first_in    = 1'b0;
      bus.data_keep_in     = '0;
      bus.data_len_in      = '0;
      bus.data_last_in     = 1'b0;
      bus.output_tready_in = 1'b0;

      repeat (3) tick();
      check_reset_outputs("rst");
      reset = 1'b0;
      tick();

      // Basic packet with idle gaps
      send_beat(64'hFF, 8'hFF, 1'b1, 1'b0, 20'd35);
      check("t1_ready_write", 128'(bus.data_ready_out), 128'd1);
      send_beat(64'h100, 8'hFF, 1'b0, 1'b0, 20'd0);
      repeat (3) tick();
      send_beat(64'h101, 8'hFF, 1'b0, 1'b0, 20'd0);
      repeat (3) tick();
      send_beat(64'h102, 8'hFF, 1'b0, 1'b0, 20'd0);
      repeat (3) tick();
      send_beat(64'h120, 8'hE0, 1'b0, 1'b1, 20'd0);
      check("t1_ack",        128'(bus.ack_o),           128'd1);
      check("t1_len",        128'(bus.output_data_len), 128'd5);
      check("t1_ready_low",  128'(bus.data_ready_out),  128'd0);
      check("t1_valid_e0",   128'(bus.output_tvalid),   128'd0);
      tick();
      check("t1_ack_pulse",  128'(bus.ack_o),           128'd0);
      check("t1_valid_e1",   128'(bus.output_tvalid),   128'd0);
      tick();
      check("t1_valid_e2",   128'(bus.output_tvalid),   128'd1);
      exp_d[0] = 64'hFF;  exp_d[1] = 64'h100; exp_d[2] = 64'h101;
      exp_d[3] = 64'h102; exp_d[4] = 64'h120;
      exp_k[0] = 8'hFF; exp_k[1] = 8'hFF; exp_k[2] = 8'hFF;
      exp_k[3] = 8'hFF; exp_k[4] = 8'hE0;
      drain("t1", 5, 64'h0, cyc_used);
      check("t1_cycles", 128'(cyc_used), 128'd5);
      check("t1_done",   128'(bus.output_done), 128'd1);
      tick();
      check("t1_done_pulse", 128'(bus.output_done),    128'd0);
      check("t1_ready_back", 128'(bus.data_ready_out), 128'd1);

      // Same packet, stalls at drain cycles 0, 2 and 5
      send_beat(64'hFF,  8'hFF, 1'b1, 1'b0, 20'd35);
      send_beat(64'h100, 8'hFF, 1'b0, 1'b0, 20'd0);
      send_beat(64'h101, 8'hFF, 1'b0, 1'b0, 20'd0);
      send_beat(64'h102, 8'hFF, 1'b0, 1'b0, 20'd0);
      send_beat(64'h120, 8'hE0, 1'b0, 1'b1, 20'd0);
      check("t2_len", 128'(bus.output_data_len), 128'd5);
      tick();
      tick();
      drain("t2", 5, 64'h25, cyc_used);
      check("t2_cycles", 128'(cyc_used), 128'd8);
      check("t2_done",   128'(bus.output_done), 128'd1);
      tick();

      // Single-beat packet
      send_beat(64'hAB, 8'h0F, 1'b1, 1'b1, 20'd1);
      check("t3_ack", 128'(bus.ack_o),           128'd1);
      check("t3_len", 128'(bus.output_data_len), 128'd1);
      tick();
      tick();
      check("t3_valid", 128'(bus.output_tvalid), 128'd1);
      exp_d[0] = 64'hAB; exp_k[0] = 8'h0F;
      drain("t3", 1, 64'h0, cyc_used);
      check("t3_done", 128'(bus.output_done), 128'd1);
      tick();

      // Packet offered during replay is ignored, then accepted after done
      send_beat(64'h11, 8'hFF, 1'b1, 1'b0, 20'd24);
      send_beat(64'h22, 8'hFF, 1'b0, 1'b0, 20'd0);
      send_beat(64'h33, 8'h3F, 1'b0, 1'b1, 20'd0);
      bus.data_in       = 64'hDEAD;
      bus.data_keep_in  = 8'hFF;
      bus.data_first_in = 1'b1;
      bus.data_last_in  = 1'b1;
      bus.data_valid_in = 1'b1;
      check("t4_ready_low", 128'(bus.data_ready_out), 128'd0);
      tick();
      tick();
      exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
      exp_k[0] = 8'hFF;  exp_k[1] = 8'hFF;  exp_k[2] = 8'h3F;
      drain("t4a", 3, 64'h0, cyc_used);
      bus.data_valid_in = 1'b0;
      bus.data_first_in = 1'b0;
      bus.data_last_in  = 1'b0;
      check("t4_done",     128'(bus.output_done),     128'd1);
      check("t4_len_kept", 128'(bus.output_data_len), 128'd3);
      tick();
      check("t4_ready_back", 128'(bus.data_ready_out), 128'd1);
      check("t4_no_ack",     128'(bus.ack_o),          128'd0);
      send_beat(64'h55, 8'hFF, 1'b1, 1'b0, 20'd9);
      send_beat(64'h66, 8'h01, 1'b0, 1'b1, 20'd0);
      check("t4b_len", 128'(bus.output_data_len), 128'd2);
      tick();
      tick();
      exp_d[0] = 64'h55; exp_d[1] = 64'h66;
      exp_k[0] = 8'hFF;  exp_k[1] = 8'h01;
      drain("t4b", 2, 64'h0, cyc_used);
      tick();

      // Reset in the middle of a write
      send_beat(64'h77, 8'hFF, 1'b1, 1'b0, 20'd16);
      send_beat(64'h78, 8'hFF, 1'b0, 1'b0, 20'd0);
      reset = 1'b1;
      tick();
      check_reset_outputs("t5");
      reset = 1'b0;
      send_beat(64'h900, 8'hFF, 1'b1, 1'b0, 20'd12);
      send_beat(64'h901, 8'h0F, 1'b0, 1'b1, 20'd0);
      check("t5_len", 128'(bus.output_data_len), 128'd2);
      tick();
      tick();
      exp_d[0] = 64'h900; exp_d[1] = 64'h901;
      exp_k[0] = 8'hFF;   exp_k[1] = 8'h0F;
      drain("t5", 2, 64'h0, cyc_used);
      tick();

      // Restart with a new first beat mid-write
      send_beat(64'hA0, 8'hFF, 1'b1, 1'b0, 20'd24);
      send_beat(64'hA1, 8'hFF, 1'b0, 1'b0, 20'd0);
      send_beat(64'hA2, 8'hFF, 1'b0, 1'b0, 20'd0);
      send_beat(64'hB0, 8'hFF, 1'b1, 1'b0, 20'd9);
      send_beat(64'hB1, 8'h80, 1'b0, 1'b1, 20'd0);
      check("t6_ack", 128'(bus.ack_o),           128'd1);
      check("t6_len", 128'(bus.output_data_len), 128'd2);
      tick();
      tick();
      exp_d[0] = 64'hB0; exp_d[1] = 64'hB1;
      exp_k[0] = 8'hFF;  exp_k[1] = 8'h80;
      drain("t6", 2, 64'h0, cyc_used);
      check("t6_done", 128'(bus.output_done), 128'd1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/srio_input_reader.md
# srio_input_reader

Single-packet store-and-forward buffer for the SRIO user-data path. It captures one packet of 64-bit beats from an upstream source into an internal RAM. It acknowledges completion, then replays the packet as an AXI-Stream-style output with first/last markers, byte keeps and a beat count. It sits between the user data generator and the SRIO request-packet builder.

## Interface
Parameters:
- DATA_WIDTH, 64, beat width in bits (multiple of 8)
- DATA_LENGTH_WIDTH, 20, width of packet byte-length field
- RAM_ADDR_WIDTH, 10, log2 of buffer depth in beats (1024 beats)

Ports:
- clk  in  1  single clock for everything
- reset  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH  input beat
- data_valid_in  in  1  beat qualifier
- data_first_in  in  1  first beat of packet (with valid)
- data_keep_in  in  DATA_WIDTH/8  byte enables of the beat
- data_len_in  in  DATA_LENGTH_WIDTH  packet byte length, sampled with first beat
- data_last_in  in  1  last beat of packet (with valid)
- data_ready_out  out  1  buffer can accept beats
- ack_o  out  1  one-cycle pulse: packet fully captured
- output_tready_in  in  1  downstream ready
- output_tdata  out  DATA_WIDTH  output beat
- output_tvalid  out  1  output beat valid
- output_tkeep  out  DATA_WIDTH/8  output byte enables
- output_tlast  out  1  last output beat
- output_tfirst  out  1  first output beat
- output_data_len  out  8  number of beats in stored packet (low 8 bits)
- output_done  out  1  one-cycle pulse after last output beat accepted

## Operation
- States: IDLE, WRITE, READ_START, READ, DONE.
- IDLE: data_ready_out=1. A beat with data_valid_in&data_first_in is written to RAM addr 0. data_len_in is latched, the beat count is set to 1, and the FSM moves to WRITE. Valid beats without first are ignored. First and last in the same beat form a 1-beat packet and go straight to READ_START.
- WRITE: data_ready_out=1. Each beat with data_valid_in writes data and keep to the next address. Cycles without valid are idle gaps of any length. A beat with data_last_in writes, then the FSM moves to READ_START. A new data_first_in in WRITE restarts the packet at addr 0.
- Overflow: beats beyond 2^RAM_ADDR_WIDTH are dropped and the count saturates. The last-beat keep is still latched.
- On leaving WRITE: ack_o pulses for 1 cycle and output_data_len is loaded with the beat count.
- READ_START: data_ready_out=0; issue read of addr 0. RAM read latency is 1 cycle.
- READ: data_ready_out=0. Beats are presented in write order.
  - output_tfirst=1 on beat 0 only.
  - output_tlast=1 on the final beat only.
  - output_tkeep is the keep stored with each beat.
  - A transfer occurs when output_tvalid&output_tready_in.
  - Use a prefetch/skid register so a beat can be sent every cycle while tready stays high.
- DONE: entered after the last transfer. output_done pulses for 1 cycle, then the FSM returns to IDLE.
- Input beats presented while data_ready_out=0 are discarded; the source must honour ready.
- The latched byte length is kept for internal use; keeps come from the stored beats.

## Timing
- Reset values: data_ready_out=1, ack_o=0, output_tvalid=0, output_tfirst=0, output_tlast=0, output_tkeep=0, output_tdata=0, output_data_len=0, output_done=0. FSM goes to IDLE. Reset mid-packet discards the packet.
- ack_o is high in the cycle after the edge that samples the last beat.
- First output_tvalid is asserted 2 cycles after the edge that samples the last beat, whatever tready is.
- Back-pressure: while output_tvalid&!output_tready_in, tdata, tkeep, tfirst and tlast hold stable.
- Throughput: 1 beat/cycle with tready held high.
- output_done is high in the cycle after the last transfer edge. data_ready_out returns to 1 in the following cycle.
- All outputs are registered.

## Test plan
- Basic packet: first beat 0xFF (keep 0xFF, len 35), then 0x100, 0x101, 0x102 each followed by 3 idle cycles, then last 0x120 keep 0xE0. Required: ack_o 1 pulse, output_data_len=5, and output 0xFF, 0x100, 0x101, 0x102, 0x120 with tfirst on 0xFF, tlast and keep 0xE0 on 0x120, and output_done 1 pulse.
- Back-pressure: same packet with tready low for 1 cycle at several points. Required: no beat lost or duplicated, and data held stable while stalled.
- Single-beat packet (first=last=1, data 0xAB, keep 0x0F). Required: one output beat with tfirst=tlast=1, keep 0x0F, and output_data_len=1.
- Back-to-back packets: a second packet offered during READ is ignored while data_ready_out=0. A second packet sent after output_done is captured and replayed correctly.
- Reset asserted mid-WRITE: all outputs return to reset values, and the next packet replays without residue.
- Restart: data_first_in again mid-WRITE. Required: only the second packet is replayed.
